// File: rtl/mcdf_ctrl_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : mcdf_ctrl_regs_if
// Brief    : Command bus between the MCDF register initiator and responder.
// Revision : 1.0 - initial release
// ============================================================================
interface mcdf_ctrl_regs_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [1:0]            cmd;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_data_w;
   logic [DATA_WIDTH-1:0] cmd_data_r;

   modport master (
      output cmd,
      output cmd_addr,
      output cmd_data_w,
      input  cmd_data_r
   );

   modport slave (
      input  cmd,
      input  cmd_addr,
      input  cmd_data_w,
      output cmd_data_r
   );
endinterface
`default_nettype wire

// File: rtl/mcdf_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : mcdf_ctrl_regs
// Brief    : MCDF control/status register file with sticky W1C error register.
// Revision : 1.0 - initial release
// ============================================================================
module mcdf_ctrl_regs #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  wire logic        clk,
   input  wire logic        rstn,
   mcdf_ctrl_regs_if.slave  bus,
   input  wire logic [7:0]  slv0_avail,
   input  wire logic [7:0]  slv1_avail,
   input  wire logic [7:0]  slv2_avail,
   output logic      [2:0]  slv0_len,
   output logic      [2:0]  slv1_len,
   output logic      [2:0]  slv2_len,
   output logic      [1:0]  slv0_prio,
   output logic      [1:0]  slv1_prio,
   output logic      [1:0]  slv2_prio,
   output logic             slv0_en,
   output logic             slv1_en,
   output logic             slv2_en,
   output logic             err_irq
);

   localparam logic [1:0] c_cmd_rd  = 2'b01;
   localparam logic [1:0] c_cmd_wr  = 2'b10;
   localparam logic [1:0] c_cmd_rsv = 2'b11;

   localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl0 = ADDR_WIDTH'('h00);
   localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl1 = ADDR_WIDTH'('h04);
   localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl2 = ADDR_WIDTH'('h08);
   localparam logic [ADDR_WIDTH-1:0] c_addr_stat0 = ADDR_WIDTH'('h10);
   localparam logic [ADDR_WIDTH-1:0] c_addr_stat1 = ADDR_WIDTH'('h14);
   localparam logic [ADDR_WIDTH-1:0] c_addr_stat2 = ADDR_WIDTH'('h18);
   localparam logic [ADDR_WIDTH-1:0] c_addr_err   = ADDR_WIDTH'('h20);

   localparam logic [5:0] c_ctrl_rst = 6'h07;

   logic [2:0][5:0]       r_ctrl;
   logic [3:0]            r_err;
   logic                  r_err_irq;
   logic [DATA_WIDTH-1:0] r_data_r;

   logic                  w_rd;
   logic                  w_wr;
   logic                  w_rsv;
   logic [2:0]            w_sel_ctrl;
   logic [2:0]            w_sel_stat;
   logic                  w_sel_err;
   logic                  w_mapped;
   logic [2:0][7:0]       w_avail;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [3:0]            w_err_set;
   logic [3:0]            w_err_clr;
   logic [3:0]            w_err_nxt;
   logic                  w_unused_wdata;

   assign w_avail = {slv2_avail, slv1_avail, slv0_avail};

   // Full-width compares make any unaligned address fall through as unmapped.
   always_comb begin
      w_rd          = (bus.cmd == c_cmd_rd);
      w_wr          = (bus.cmd == c_cmd_wr);
      w_rsv         = (bus.cmd == c_cmd_rsv);
      w_sel_ctrl[0] = (bus.cmd_addr == c_addr_ctrl0);
      w_sel_ctrl[1] = (bus.cmd_addr == c_addr_ctrl1);
      w_sel_ctrl[2] = (bus.cmd_addr == c_addr_ctrl2);
      w_sel_stat[0] = (bus.cmd_addr == c_addr_stat0);
      w_sel_stat[1] = (bus.cmd_addr == c_addr_stat1);
      w_sel_stat[2] = (bus.cmd_addr == c_addr_stat2);
      w_sel_err     = (bus.cmd_addr == c_addr_err);
      w_mapped      = (|w_sel_ctrl) | (|w_sel_stat) | w_sel_err;
   end

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         if (w_sel_ctrl[i]) w_rdata = DATA_WIDTH'(r_ctrl[i]);
         if (w_sel_stat[i]) w_rdata = DATA_WIDTH'(w_avail[i]);
      end
      if (w_sel_err) w_rdata = DATA_WIDTH'(r_err);
   end

   // Sets are OR-ed in after the clear so a same-edge set always wins.
   always_comb begin
      w_err_set = {w_rsv,
                   w_wr & (|w_sel_stat),
                   w_wr & ~w_mapped,
                   w_rd & ~w_mapped};
      w_err_clr = (w_wr && w_sel_err) ? bus.cmd_data_w[3:0] : 4'h0;
      w_err_nxt = (r_err & ~w_err_clr) | w_err_set;
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_ctrl    <= {3{c_ctrl_rst}};
         r_err     <= 4'h0;
         r_err_irq <= 1'b0;
         r_data_r  <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (w_wr && w_sel_ctrl[i]) r_ctrl[i] <= bus.cmd_data_w[5:0];
         end
         r_err     <= w_err_nxt;
         r_err_irq <= |w_err_nxt;
         r_data_r  <= w_rd ? w_rdata : '0;
      end
   end

   assign w_unused_wdata = ^bus.cmd_data_w[DATA_WIDTH-1:6];

   assign bus.cmd_data_r = r_data_r;
   assign err_irq        = r_err_irq;

   assign slv0_en   = r_ctrl[0][0];
   assign slv0_prio = r_ctrl[0][2:1];
   assign slv0_len  = r_ctrl[0][5:3];
   assign slv1_en   = r_ctrl[1][0];
   assign slv1_prio = r_ctrl[1][2:1];
   assign slv1_len  = r_ctrl[1][5:3];
   assign slv2_en   = r_ctrl[2][0];
   assign slv2_prio = r_ctrl[2][2:1];
   assign slv2_len  = r_ctrl[2][5:3];

endmodule
`default_nettype wire
